key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter.sv | 192 +++++++++++++++++++
 tb/tb_key_filter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_filter.sv
// key_filter: conditions raw push-buttons and slide switches.
// Every input passes a two-flop synchronizer and a stability counter; each key
// runs a press/release FSM that emits one-cycle press and release pulses.
// All outputs are registered; a pin change shows up DEB_CYC+3 cycles later.
// Optional long-press detection is built when KEY_FILTER_LONGPRESS_EN is defined.
module key_filter #(
  parameter int N_KEY    = 4,
  parameter int N_SW     = 4,
  parameter int DEB_CYC  = 240000,
  parameter int LONG_CYC = 12000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] key,
  input  logic [N_SW-1:0]  sw,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_long,
  output logic [N_SW-1:0]  sw_level
);

  localparam int            CW   = $clog2(DEB_CYC + 1);
  localparam logic [CW-1:0] HIT  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } kstate_t;

  logic [N_KEY-1:0] r_key_s1, r_key_s2;
  logic [N_SW-1:0]  r_sw_s1, r_sw_s2;

  logic [CW-1:0]    r_kcnt [N_KEY];
  kstate_t          r_kstate [N_KEY];
  kstate_t          w_knext [N_KEY];
  logic [N_KEY-1:0] w_kp, w_kheld, w_kdiff, w_khit;

  logic [CW-1:0]    r_scnt [N_SW];
  logic [N_SW-1:0]  r_sw_deb;
  logic [N_SW-1:0]  w_sdiff, w_shit;

  logic [N_KEY-1:0] r_key_level, r_key_press, r_key_release;
  logic [N_SW-1:0]  r_sw_level;

  // Two-flop synchronizers; keys idle released (1), switches idle off (0).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= key;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Per-key pressed flag, debounced level and counter terminal condition.
  always_comb begin
    w_kp    = '0;
    w_kheld = '0;
    w_kdiff = '0;
    w_khit  = '0;
    for (int i = 0; i < N_KEY; i++) begin
      w_kp[i]    = ~r_key_s2[i];
      w_kheld[i] = (r_kstate[i] == S_HELD) || (r_kstate[i] == S_RELEASE_WAIT);
      w_kdiff[i] = w_kp[i] ^ w_kheld[i];
      w_khit[i]  = w_kdiff[i] && (r_kcnt[i] == HIT);
    end
  end

  // Key FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEY; i++) r_kstate[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < N_KEY; i++) r_kstate[i] <= w_knext[i];
    end
  end

  // Key FSM next state: a wait state falls back without a pulse if the
  // synchronized pin returns before the counter completes.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      w_knext[i] = r_kstate[i];
      case (r_kstate[i])
        S_IDLE:         if (w_kp[i]) w_knext[i] = w_khit[i] ? S_HELD : S_PRESS_WAIT;
        S_PRESS_WAIT:   if (!w_kp[i]) w_knext[i] = S_IDLE;
                        else if (w_khit[i]) w_knext[i] = S_HELD;
        S_HELD:         if (!w_kp[i]) w_knext[i] = w_khit[i] ? S_IDLE : S_RELEASE_WAIT;
        S_RELEASE_WAIT: if (w_kp[i]) w_knext[i] = S_HELD;
                        else if (w_khit[i]) w_knext[i] = S_IDLE;
        default:        w_knext[i] = S_IDLE;
      endcase
    end
  end

  // Key stability counters: clear while pin agrees with the level or on a flip,
  // otherwise count up, holding at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEY; i++) r_kcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEY; i++) begin
        if (!w_kdiff[i] || w_khit[i]) r_kcnt[i] <= '0;
        else if (r_kcnt[i] != CMAX)   r_kcnt[i] <= r_kcnt[i] + 1'b1;
      end
    end
  end

  // Switch disagreement and counter terminal condition.
  always_comb begin
    w_sdiff = r_sw_s2 ^ r_sw_deb;
    w_shit  = '0;
    for (int i = 0; i < N_SW; i++) w_shit[i] = w_sdiff[i] && (r_scnt[i] == HIT);
  end

  // Switch debouncers: same counter rule, level only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw_deb <= '0;
      for (int i = 0; i < N_SW; i++) r_scnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (w_shit[i]) begin
          r_sw_deb[i] <= ~r_sw_deb[i];
          r_scnt[i]   <= '0;
        end else if (!w_sdiff[i]) begin
          r_scnt[i] <= '0;
        end else if (r_scnt[i] != CMAX) begin
          r_scnt[i] <= r_scnt[i] + 1'b1;
        end
      end
    end
  end

  // Output registers; edges of the registered level give one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_level   <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
      r_sw_level    <= '0;
    end else begin
      r_key_level   <= w_kheld;
      r_key_press   <= w_kheld & ~r_key_level;
      r_key_release <= ~w_kheld & r_key_level;
      r_sw_level    <= r_sw_deb;
    end
  end

  assign key_level   = r_key_level;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;
  assign sw_level    = r_sw_level;

`ifdef KEY_FILTER_LONGPRESS_EN
  localparam int            LW   = $clog2(LONG_CYC + 2);
  localparam logic [LW-1:0] LHIT = LW'(LONG_CYC);
  localparam logic [LW-1:0] LSAT = LW'(LONG_CYC + 1);

  logic [LW-1:0]    r_lcnt [N_KEY];
  logic [N_KEY-1:0] r_key_long;

  // Long-press counters run while the key is held (release glitches included),
  // stop one past the trigger value so the pulse fires once per hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key_long <= '0;
      for (int i = 0; i < N_KEY; i++) r_lcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEY; i++) begin
        r_key_long[i] <= w_kheld[i] && (r_lcnt[i] == LHIT);
        if (!w_kheld[i])          r_lcnt[i] <= '0;
        else if (r_lcnt[i] != LSAT) r_lcnt[i] <= r_lcnt[i] + 1'b1;
      end
    end
  end

  assign key_long = r_key_long;
`else
  // Long-press detection not built: output tied low, LONG_CYC has no hardware.
  assign key_long = {N_KEY{1'b0}} & {N_KEY{LONG_CYC > 0}};
`endif

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter (DEB_CYC=8, LONG_CYC=32): directed scenarios followed by
// random pin activity, compared every cycle with a window-based reference model.
module tb_key_filter;
  localparam int NK   = 4;
  localparam int NS   = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int NCYC = 6000;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key   = '1;
  logic [NS-1:0] sw    = '0;
  logic [NK-1:0] key_level, key_press, key_release, key_long;
  logic [NS-1:0] sw_level;

  key_filter #(.N_KEY(NK), .N_SW(NS), .DEB_CYC(DEB), .LONG_CYC(LONG)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .sw(sw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .sw_level(sw_level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Pin and reset values present during each cycle (sampled at the next edge).
  logic [NK-1:0] h_key [NCYC];
  logic [NS-1:0] h_sw  [NCYC];
  logic          h_rst [NCYC];
  // Model levels per cycle.
  logic [NK-1:0] m_klev [NCYC];
  logic [NS-1:0] m_slev [NCYC];

  logic [NK-1:0] cur_key;
  logic [NS-1:0] cur_sw;
  int rate, rst_left;
  int k1_evt = 0, k2_press = 0, k1_p2 = 0, k0_rel = 0, long_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic in_rst(int c);
    return (c < 0) ? 1'b1 : h_rst[c];
  endfunction

  // Active value of a pin as it leaves the synchronizer; reset forces inactive.
  function automatic logic pin_on(int c, logic is_key, int b);
    if (c < 0 || in_rst(c) || in_rst(c + 1)) return 1'b0;
    return is_key ? ~h_key[c][b] : h_sw[c][b];
  endfunction

  // The level flips once the pin has shown the opposite value for DEB
  // consecutive cycles, seen DEB+3 cycles later at the output.
  function automatic logic model_level(int t, logic prev, logic is_key, int b);
    if (in_rst(t - 1) || in_rst(t - 2)) return 1'b0;
    for (int c = t - DEB - 3; c <= t - 4; c++)
      if (pin_on(c, is_key, b) == prev) return prev;
    return ~prev;
  endfunction

  task automatic model_check(input int t);
    logic [NK-1:0] pk, lk, ek, rk, gk;
    logic [NS-1:0] ps, ls;
    pk = (t > 0) ? m_klev[t-1] : '0;
    ps = (t > 0) ? m_slev[t-1] : '0;
    lk = '0;
    ls = '0;
    gk = '0;
    for (int b = 0; b < NK; b++) lk[b] = model_level(t, pk[b], 1'b1, b);
    for (int b = 0; b < NS; b++) ls[b] = model_level(t, ps[b], 1'b0, b);
    m_klev[t] = lk;
    m_slev[t] = ls;
    ek = lk & ~pk;
    rk = in_rst(t - 1) ? '0 : (~lk & pk);
`ifdef KEY_FILTER_LONGPRESS_EN
    // Long pulse: pressed exactly LONG cycles ago and level high ever since.
    if (t > LONG) begin
      for (int b = 0; b < NK; b++) begin
        gk[b] = ~m_klev[t-LONG-1][b] & lk[b];
        for (int s = t - LONG; s < t; s++) gk[b] = gk[b] & m_klev[s][b];
      end
    end
`endif
    chk("key_level", key_level, lk);
    chk("key_press", key_press, ek);
    chk("key_release", key_release, rk);
    chk("key_long", key_long, gk);
    chk("sw_level", sw_level, ls);
  endtask

  task automatic drive(input int t);
    logic nrst;
    logic [NK-1:0] nk;
    logic [NS-1:0] ns;
    nrst = 1'b1;
    nk = '1;
    ns = '0;
    if (t < 3) begin
      nrst = 1'b0;
    end else if (t < 200) begin
      nk[0] = !(t >= 10 && t < 150);
      nk[1] = !(t >= 10 && t < 15);
      if (t >= 20 && t < 32) nk[2] = (((t - 20) / 3) % 2) != 0;
      else nk[2] = !(t >= 32 && t < 100);
      nk[3] = !(t >= 10 && t < 30);
      ns[3] = (t >= 10);
      ns[0] = (t >= 60 && t < 64);
    end else if (t < 400) begin
      nrst  = !(t == 205 || t == 206);
      nk[1] = !(t < 260);
      nk[0] = !(t >= 270 && t < 340 && !(t >= 300 && t < 303));
      ns[3] = 1'b1;
    end else begin
      if (t == 400) begin
        cur_key = '1;
        cur_sw = '0;
        rate = 3;
        rst_left = 0;
      end
      if (t % 200 == 0) rate = $urandom_range(1, 6);
      if (t < NCYC - 60) begin
        for (int b = 0; b < NK; b++)
          if ($urandom_range(0, (1 << rate) - 1) == 0) cur_key[b] = ~cur_key[b];
        for (int b = 0; b < NS; b++)
          if ($urandom_range(0, (1 << rate) - 1) == 0) cur_sw[b] = ~cur_sw[b];
        if (rst_left > 0) begin
          nrst = 1'b0;
          rst_left--;
        end else if ($urandom_range(0, 399) == 0) begin
          nrst = 1'b0;
          rst_left = $urandom_range(0, 2);
        end
      end
      nk = cur_key;
      ns = cur_sw;
    end
    rst_n = nrst;
    key = nk;
    sw = ns;
    h_rst[t] = ~nrst;
    h_key[t] = nk;
    h_sw[t] = ns;
  endtask

  initial begin
    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk);
      #1;
      cyc = t;
      model_check(t);
      if (t == 3) begin
        chk("rst_key_level", key_level, 0);
        chk("rst_key_press", key_press, 0);
        chk("rst_key_release", key_release, 0);
        chk("rst_key_long", key_long, 0);
        chk("rst_sw_level", sw_level, 0);
      end
      if (t >= 10 && t < 100) begin
        k1_evt += int'(key_press[1]) + int'(key_level[1]);
        k2_press += int'(key_press[2]);
      end
      if (t == 20) begin
        chk("press0_early", key_press[0], 0);
        chk("sw3_early", sw_level[3], 0);
      end
      if (t == 21) begin
        chk("press0_lat11", key_press[0], 1);
        chk("level0_lat11", key_level[0], 1);
        chk("press3_same_cycle", key_press[3], 1);
        chk("sw3_lat11", sw_level[3], 1);
      end
      if (t == 22) chk("press0_one_cycle", key_press[0], 0);
      if (t == 43) chk("bounce_press", key_press[2], 1);
      if (t == 100) begin
        chk("short_low_rejected", k1_evt, 0);
        chk("bounce_single_press", k2_press, 1);
      end
      if (t == 110) chk("release2_early", key_release[2], 0);
      if (t == 111) chk("release2_lat11", key_release[2], 1);
`ifdef KEY_FILTER_LONGPRESS_EN
      if (t == 52) chk("long0_early", key_long[0], 0);
      if (t == 53) chk("long0_at32", key_long[0], 1);
      if (t == 313) chk("long0_through_glitch", key_long[0], 1);
`else
      if (key_long != '0) long_seen++;
`endif
      if (t == 206) begin
        chk("midrst_key_level", key_level, 0);
        chk("midrst_sw_level", sw_level, 0);
      end
      if (t >= 206 && t < 218) k1_p2 += int'(key_press != '0) + int'(key_release != '0);
      if (t == 218) begin
        chk("rst_no_early_pulse", k1_p2, 0);
        chk("press1_after_rst", key_press[1], 1);
      end
      if (t >= 282 && t < 351) k0_rel += int'(key_release[0]);
      if (t == 351) begin
        chk("release_glitch_rejected", k0_rel, 0);
        chk("release0_lat11", key_release[0], 1);
      end
      drive(t);
    end
`ifndef KEY_FILTER_LONGPRESS_EN
    chk("long_disabled", long_seen, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
